// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared rename/commit constants and physical register type
//
// Holds the physical/architectural register counts and the PhysReg type that
// the free list, rename map table and commit stage all agree on.
package mips_core_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = $clog2(NUM_PREGS);

    typedef logic [PREG_W-1:0] PhysReg;

endpackage

// File: rtl/free_list_bitmap.sv
// rtl/free_list_bitmap.sv - membership bitmap and duplicate-release detect for the free list
//
// One bit per physical register: set while that register sits in the free list.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alloc_fire      a register is leaving the list this cycle (alloc_preg)
//   alloc_preg      register being granted
//   release_accept  release_preg is being written into the list this cycle
//   release_preg    register offered by the commit stage
//   release_dup     combinational: release_preg is already free (duplicate)
module free_list_bitmap #(
    parameter int  NUM_PREGS = mips_core_pkg::NUM_PREGS,
    parameter int  NUM_AREGS = mips_core_pkg::NUM_AREGS,
    localparam int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_fire,
    input  logic [PREG_W-1:0] alloc_preg,
    input  logic              release_accept,
    input  logic [PREG_W-1:0] release_preg,
    output logic              release_dup
);

    logic [NUM_PREGS-1:0] in_list;

    // A register leaving the list in the same cycle it is returned is not a
    // duplicate: the grant and the return are two distinct lifetimes.
    assign release_dup = in_list[release_preg] &&
                         !(alloc_fire && (alloc_preg == release_preg));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_list[i] <= (i >= NUM_AREGS);
            end
        end else begin
            if (alloc_fire) begin
                in_list[alloc_preg] <= 1'b0;
            end
            // Ordered after the clear so a coinciding grant/return nets to set.
            if (release_accept) begin
                in_list[release_preg] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular FIFO of free physical register IDs for rename
//
// Rename pulls one free preg per cycle; commit returns one superseded preg per
// cycle. Optional duplicate-release checking is enabled by defining
// FREE_LIST_DOUBLE_FREE_CHECK_EN (adds free_list_bitmap); otherwise
// double_free_err is tied low and duplicates are enqueued like any release.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   alloc_req        rename wants a preg this cycle
//   alloc_valid      list non-empty (registered state only)
//   alloc_preg       preg at head (registered state only)
//   release_valid    commit returns release_preg this cycle
//   release_preg     returned preg; preg 0 is $zero and is ignored
//   free_count       entries currently in the list
//   full             free_count == DEPTH
//   overflow_err     sticky: release dropped because the list was full
//   double_free_err  sticky: duplicate release dropped
module phys_reg_free_list #(
    parameter int  NUM_PREGS = mips_core_pkg::NUM_PREGS,
    parameter int  NUM_AREGS = mips_core_pkg::NUM_AREGS,
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS,
    localparam int PREG_W    = $clog2(NUM_PREGS),
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              release_valid,
    input  logic [PREG_W-1:0] release_preg,
    output logic [CNT_W-1:0]  free_count,
    output logic              full,
    output logic              overflow_err,
    output logic              double_free_err
);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;

    logic alloc_fire;
    logic release_live;
    logic has_space;
    logic release_dup;
    logic release_accept;
    logic release_full_drop;

    // Grant side depends only on registered head/count, never on alloc_req,
    // so rename sees a stable grant early in the cycle.
    assign alloc_valid = (count != '0);
    assign alloc_preg  = mem[head];
    assign alloc_fire  = alloc_req && alloc_valid;

    assign release_live = release_valid && (release_preg != '0);
    // When full, a same-cycle grant frees the head slot, which is exactly
    // where tail points, so the write can land there.
    assign has_space    = (count < CNT_W'(DEPTH)) || alloc_fire;

    assign release_accept    = release_live && has_space && !release_dup;
    assign release_full_drop = release_live && !has_space && !release_dup;

    assign free_count   = count;
    assign full         = (count == CNT_W'(DEPTH));
    assign overflow_err = overflow_q;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic double_free_q;

    free_list_bitmap #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_AREGS (NUM_AREGS)
    ) u_bitmap (
        .clk            (clk),
        .rst            (rst),
        .alloc_fire     (alloc_fire),
        .alloc_preg     (alloc_preg),
        .release_accept (release_accept),
        .release_preg   (release_preg),
        .release_dup    (release_dup)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            double_free_q <= 1'b0;
        end else if (release_live && release_dup) begin
            double_free_q <= 1'b1;
        end
    end

    assign double_free_err = double_free_q;
`else
    assign release_dup     = 1'b0;
    assign double_free_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(NUM_AREGS + i);
            end
            head       <= '0;
            tail       <= '0;
            count      <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            if (release_accept) begin
                mem[tail] <= release_preg;
                tail      <= tail + PTR_W'(1);
            end
            if (alloc_fire) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(release_accept) - CNT_W'(alloc_fire);
            if (release_full_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed vector bench for phys_reg_free_list
module tb_phys_reg_free_list;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    localparam bit DF_EN = 1'b1;
`else
    localparam bit DF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       release_valid;
    logic [5:0] release_preg;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic [5:0] free_count;
    logic       full;
    logic       overflow_err;
    logic       double_free_err;

    phys_reg_free_list dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_preg      (alloc_preg),
        .release_valid   (release_valid),
        .release_preg    (release_preg),
        .free_count      (free_count),
        .full            (full),
        .overflow_err    (overflow_err),
        .double_free_err (double_free_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       areq;
        logic       rv;
        logic [5:0] rp;
        logic       ev;
        logic [5:0] ep;
        logic [5:0] ec;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic r, logic a, logic v, logic [5:0] p,
                                logic ev, logic [5:0] ep, logic [5:0] ec,
                                logic ef, logic eo);
        vec_t t;
        t.rst = r;  t.areq = a;  t.rv = v;  t.rp = p;
        t.ev = ev;  t.ep = ep;   t.ec = ec; t.ef = ef; t.eo = eo;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled 1ns later, well before
    // the next rising edge.
    task automatic step(logic r, logic a, logic v, logic [5:0] p);
        @(negedge clk);
        rst = r; alloc_req = a; release_valid = v; release_preg = p;
        #1;
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1; alloc_req = 1'b0; release_valid = 1'b0; release_preg = '0;
        repeat (2) @(posedge clk);

        // Reset state
        add(0,0,0,0, 1,32,32,1,0);
        // Drain from reset: 32..63 then empty
        for (int k = 0; k < 32; k++) add(0,1,0,0, 1,6'(32+k),6'(32-k),(k==0),0);
        add(0,1,0,0, 0,0,0,0,0);
        // Empty: release 40 with alloc_req held, no bypass, granted next cycle
        add(0,1,1,40, 0,0,0,0,0);
        add(0,1,0,0, 1,40,1,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // Release of preg 0 is ignored
        add(0,0,1,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // Reset with stray requests, then reset state again
        add(1,1,1,9, 0,0,0,0,0);
        add(0,0,0,0, 1,32,32,1,0);
        // Full: preg 0 no overflow, preg 5 dropped with overflow
        add(0,0,1,0, 1,32,32,1,0);
        add(0,0,1,5, 1,32,32,1,0);
        add(0,0,0,0, 1,32,32,1,1);
        // Full with alloc + release 7: both succeed, 7 comes after 33..63
        add(0,1,1,7, 1,32,32,1,1);
        for (int k = 0; k < 31; k++) add(0,1,0,0, 1,6'(33+k),6'(32-k),(k==0),1);
        add(0,1,0,0, 1,7,1,0,1);
        add(0,0,0,0, 0,0,0,0,1);
        // Mid-stream reset after 10 allocations and 3 releases
        add(1,0,0,0, 0,0,0,0,1);
        add(0,0,1,5, 1,32,32,1,0);
        for (int k = 0; k < 10; k++) add(0,1,0,0, 1,6'(32+k),6'(32-k),(k==0),1);
        for (int k = 0; k < 3; k++)  add(0,0,1,6'(32+k), 1,42,6'(22+k),0,1);
        add(1,1,1,35, 1,42,25,0,1);
        add(0,0,0,0, 1,32,32,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].areq, vecs[i].rv, vecs[i].rp);
            check($sformatf("v%0d alloc_valid", i), 32'(alloc_valid), 32'(vecs[i].ev));
            if (vecs[i].ev)
                check($sformatf("v%0d alloc_preg", i), 32'(alloc_preg), 32'(vecs[i].ep));
            check($sformatf("v%0d free_count", i), 32'(free_count), 32'(vecs[i].ec));
            check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].ef));
            check($sformatf("v%0d overflow_err", i), 32'(overflow_err), 32'(vecs[i].eo));
            check($sformatf("v%0d double_free_err", i), 32'(double_free_err), 32'(0));
        end

        // Duplicate release from empty: dropped with the check, enqueued without
        step(1,0,0,0);
        for (int k = 0; k < 32; k++) begin
            step(0,1,0,0);
            check($sformatf("drain%0d preg", k), 32'(alloc_preg), 32'(32+k));
        end
        step(0,0,1,32);
        check("dup empty valid", 32'(alloc_valid), 32'(0));
        step(0,0,1,32);
        check("dup first count", 32'(free_count), 32'(1));
        check("dup first preg", 32'(alloc_preg), 32'(32));
        exp_cnt = DF_EN ? 1 : 2;
        step(0,0,1,0);
        check("dup second count", 32'(free_count), 32'(exp_cnt));
        check("dup second err", 32'(double_free_err), 32'(DF_EN));
        step(0,0,0,0);
        check("dup zero count", 32'(free_count), 32'(exp_cnt));
        // Grant of 32 coinciding with its return is a legal release
        step(0,1,1,32);
        check("coincide preg", 32'(alloc_preg), 32'(32));
        step(0,0,0,0);
        check("coincide count", 32'(free_count), 32'(exp_cnt));
        check("coincide err", 32'(double_free_err), 32'(DF_EN));
        check("coincide ovf", 32'(overflow_err), 32'(0));
        step(0,1,0,0);
        check("post preg", 32'(alloc_preg), 32'(32));
        step(0,0,0,0);
        check("post count", 32'(free_count), 32'(exp_cnt - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
